// File: rtl/seven_seg_pkg.sv
// Shared constants, payload type and helpers for the seven-segment display sequencer.
package seven_seg_pkg;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DATA_W  = DIGITS * NIBBLE_W;

  localparam logic [DIGITS-1:0] ANODE_D0  = 4'b1110;
  localparam logic [DIGITS-1:0] ANODE_D1  = 4'b1101;
  localparam logic [DIGITS-1:0] ANODE_D2  = 4'b1011;
  localparam logic [DIGITS-1:0] ANODE_D3  = 4'b0111;
  localparam logic [DIGITS-1:0] ANODE_OFF = 4'hF;
  localparam logic [SEG_W-1:0]  SEG_OFF   = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; leftmost entry is nibble F.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DIGITS-1:0] dp;
    logic [DIGITS-1:0] blank;
  } disp_word_t;

  localparam disp_word_t DISP_RESET = '{data: 16'h0000, dp: 4'h0, blank: 4'hF};

  function automatic logic [DIGITS-1:0] anode_for(input logic [1:0] digit);
    case (digit)
      2'd0:    anode_for = ANODE_D0;
      2'd1:    anode_for = ANODE_D1;
      2'd2:    anode_for = ANODE_D2;
      default: anode_for = ANODE_D3;
    endcase
  endfunction

  // Leading-zero test: digit d>0 is dark when it and every digit above it is zero.
  function automatic logic lz_blank(input logic [DATA_W-1:0] data, input logic [1:0] digit);
    case (digit)
      2'd1:    lz_blank = (data[15:4] == 12'h000);
      2'd2:    lz_blank = (data[15:8] == 8'h00);
      2'd3:    lz_blank = (data[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment cathode pattern.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg_c
);

  assign seg_c = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_display_sequencer.sv
// Four-digit common-anode scan sequencer with dimming, leading-zero blanking and
// frame-boundary commit of new display words.
module seven_seg_display_sequencer
  import seven_seg_pkg::*;
#(
  parameter int unsigned BRIGHT_W    = 2,
  parameter bit          LZ_SUPPRESS = 1'b1
) (
  input  logic                div_clock,
  input  logic                reset,
  input  logic                load_valid,
  input  logic [DATA_W-1:0]   load_data,
  input  logic [DIGITS-1:0]   load_dp,
  input  logic [DIGITS-1:0]   load_blank,
  output logic                load_ready,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [DIGITS-1:0]   anode,
  output logic [SEG_W-1:0]    cathode,
  output logic                dp_n,
  output logic                frame_done
);

  localparam int unsigned          SUB_SLOTS = 2 ** BRIGHT_W;
  localparam logic [BRIGHT_W-1:0] SUB_LAST  = BRIGHT_W'(SUB_SLOTS - 1);

  logic [BRIGHT_W-1:0] sub_q, sub_n, bright_q, bright_n;
  logic [1:0]          digit_q, digit_n;
  disp_word_t          pending_q, active_q, active_n;

  logic                sub_wrap, boundary, boundary_n, accept, commit, blanked, lit;
  logic [DATA_W-1:0]   shifted_data;
  logic [NIBBLE_W-1:0] nibble;
  logic [SEG_W-1:0]    seg_c;
  logic [DIGITS-1:0]   anode_n;
  logic [SEG_W-1:0]    cathode_n;
  logic                dp_n_n;

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg_c  (seg_c)
  );

  // Next counter/commit state; outputs are decoded from the next state so the
  // registered pins line up with the (digit, sub) they belong to.
  always_comb begin
    sub_wrap     = (sub_q == SUB_LAST);
    boundary     = sub_wrap && (digit_q == 2'd3);
    sub_n        = sub_wrap ? '0 : sub_q + BRIGHT_W'(1);
    digit_n      = sub_wrap ? digit_q + 2'd1 : digit_q;
    bright_n     = (sub_n == '0) ? brightness : bright_q;
    boundary_n   = (sub_n == SUB_LAST) && (digit_n == 2'd3);
    accept       = load_valid && load_ready;
    commit       = boundary && !load_ready;
    active_n     = commit ? pending_q : active_q;
    shifted_data = active_n.data >> {digit_n, 2'b00};
    nibble       = shifted_data[NIBBLE_W-1:0];
    blanked      = active_n.blank[digit_n] || (LZ_SUPPRESS && lz_blank(active_n.data, digit_n));
    lit          = (sub_n <= bright_n) && !blanked;
    anode_n      = ANODE_OFF;
    cathode_n    = SEG_OFF;
    dp_n_n       = 1'b1;
    if (lit) begin
      anode_n   = anode_for(digit_n);
      cathode_n = seg_c;
      dp_n_n    = ~active_n.dp[digit_n];
    end
  end

  // load_ready doubles as the pending-empty flag.
  always_ff @(posedge div_clock or posedge reset) begin
    if (reset) begin
      sub_q      <= '0;
      digit_q    <= 2'd0;
      bright_q   <= '0;
      pending_q  <= DISP_RESET;
      active_q   <= DISP_RESET;
      load_ready <= 1'b1;
      anode      <= ANODE_OFF;
      cathode    <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      sub_q      <= sub_n;
      digit_q    <= digit_n;
      bright_q   <= bright_n;
      active_q   <= active_n;
      anode      <= anode_n;
      cathode    <= cathode_n;
      dp_n       <= dp_n_n;
      frame_done <= boundary_n;
      if (accept) begin
        pending_q  <= '{data: load_data, dp: load_dp, blank: load_blank};
        load_ready <= 1'b0;
      end else if (commit) begin
        load_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_display_sequencer.sv
// Directed bench for the seven-segment display sequencer.
module tb_seven_seg_display_sequencer;

  logic        div_clock = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [3:0]  load_blank;
  logic        load_ready;
  logic [1:0]  brightness;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp_n;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int pos   = 0;

  localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  seven_seg_display_sequencer dut (
    .div_clock  (div_clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .load_blank (load_blank),
    .load_ready (load_ready),
    .brightness (brightness),
    .anode      (anode),
    .cathode    (cathode),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 div_clock = ~div_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge div_clock);
    #1;
    pos = (pos + 1) % 16;
  endtask

  task automatic goto_pos(input int p);
    for (int i = 0; i < 16 && pos != p; i++) tick();
  endtask

  // Checks one frame from pos 0; an/cat/dpn hold the per-slot patterns (slot 0 in the low bits).
  task automatic check_frame(input string tag, input logic [15:0] an, input logic [27:0] cat,
                             input logic [3:0] dpn, input int lit_n);
    for (int p = 0; p < 16; p++) begin
      int  d;
      logic lit;
      d   = p / 4;
      lit = (p % 4) < lit_n;
      chk($sformatf("%s anode p%0d", tag, p), 32'(anode), lit ? 32'(an[4*d +: 4]) : 32'hF);
      chk($sformatf("%s cathode p%0d", tag, p), 32'(cathode), lit ? 32'(cat[7*d +: 7]) : 32'h7F);
      chk($sformatf("%s dp_n p%0d", tag, p), 32'(dp_n), lit ? 32'(dpn[d]) : 32'h1);
      chk($sformatf("%s frame_done p%0d", tag, p), 32'(frame_done), (p == 15) ? 32'h1 : 32'h0);
      tick();
    end
  endtask

  task automatic load(input logic [15:0] data, input logic [3:0] dp, input logic [3:0] blank);
    load_valid = 1'b1;
    load_data  = data;
    load_dp    = dp;
    load_blank = blank;
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0;
    load_dp    = 4'h0;
    load_blank = 4'h0;
    brightness = 2'd3;
    #1;
    chk("reset anode", 32'(anode), 32'hF);
    chk("reset cathode", 32'(cathode), 32'h7F);
    chk("reset dp_n", 32'(dp_n), 32'h1);
    chk("reset frame_done", 32'(frame_done), 32'h0);
    chk("reset load_ready", 32'(load_ready), 32'h1);
    repeat (2) @(posedge div_clock);
    @(negedge div_clock);
    reset = 1'b0;
    pos   = 0;

    // 1: idle after reset, everything dark, frame_done every 16 cycles
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("idle anode c%0d", i), 32'(anode), 32'hF);
      chk($sformatf("idle frame_done c%0d", i), 32'(frame_done), (pos == 15) ? 32'h1 : 32'h0);
    end

    // 2: 16'h1234 at full brightness
    goto_pos(2);
    load(16'h1234, 4'h0, 4'h0);
    tick();
    load_valid = 1'b0;
    chk("t2 ready after accept", 32'(load_ready), 32'h0);
    chk("t2 no early commit", 32'(anode), 32'hF);
    goto_pos(0);
    chk("t2 ready after commit", 32'(load_ready), 32'h1);
    check_frame("t2", AN_ALL, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4);

    // 3: brightness 0 -> one lit sub-cycle per slot
    goto_pos(15);
    brightness = 2'd0;
    tick();
    check_frame("t3", AN_ALL, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1);
    brightness = 2'd3;

    // 4: leading-zero suppression, with digit0 decimal point
    goto_pos(4);
    load(16'h0050, 4'b0001, 4'h0);
    tick();
    load_valid = 1'b0;
    goto_pos(0);
    check_frame("t4a", {4'hF, 4'hF, 4'b1101, 4'b1110}, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1110, 4);
    goto_pos(3);
    load(16'h0000, 4'h0, 4'h0);
    tick();
    load_valid = 1'b0;
    goto_pos(0);
    check_frame("t4b", {4'hF, 4'hF, 4'hF, 4'b1110}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 4);

    // 5: back-to-back words A then B held on the bus
    goto_pos(5);
    load(16'hABCD, 4'h0, 4'h0);
    tick();
    chk("t5 ready after A", 32'(load_ready), 32'h0);
    load(16'h9876, 4'h0, 4'b0100);
    goto_pos(8);
    chk("t5 old word mid-frame", 32'(anode), 32'hF);
    goto_pos(15);
    chk("t5 B held off", 32'(load_ready), 32'h0);
    tick();
    chk("t5 ready after A commit", 32'(load_ready), 32'h1);
    check_frame("t5A", AN_ALL, {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, 4);
    load_valid = 1'b0;
    chk("t5 ready after B commit", 32'(load_ready), 32'h1);
    check_frame("t5B", {4'b0111, 4'hF, 4'b1101, 4'b1110}, {7'h10, 7'h7F, 7'h78, 7'h02}, 4'hF, 4);

    // 6a: accept on the boundary cycle commits one frame later
    goto_pos(15);
    load(16'h5A5A, 4'h0, 4'h0);
    tick();
    load_valid = 1'b0;
    chk("t6 ready after boundary accept", 32'(load_ready), 32'h0);
    chk("t6 old word digit0", 32'(cathode), 32'h02);
    goto_pos(15);
    chk("t6 still pending", 32'(load_ready), 32'h0);
    tick();
    chk("t6 new anode", 32'(anode), 32'hE);
    chk("t6 new cathode", 32'(cathode), 32'h08);
    chk("t6 ready", 32'(load_ready), 32'h1);

    // 6b: reset mid-frame with a pending word
    goto_pos(3);
    load(16'h8888, 4'hF, 4'h0);
    tick();
    load_valid = 1'b0;
    chk("t6 pending full", 32'(load_ready), 32'h0);
    goto_pos(6);
    reset = 1'b1;
    #1;
    chk("midreset anode", 32'(anode), 32'hF);
    chk("midreset cathode", 32'(cathode), 32'h7F);
    chk("midreset dp_n", 32'(dp_n), 32'h1);
    chk("midreset frame_done", 32'(frame_done), 32'h0);
    chk("midreset load_ready", 32'(load_ready), 32'h1);
    repeat (2) @(posedge div_clock);
    @(negedge div_clock);
    reset = 1'b0;
    pos   = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("postreset anode c%0d", i), 32'(anode), 32'hF);
      chk($sformatf("postreset cathode c%0d", i), 32'(cathode), 32'h7F);
      chk($sformatf("postreset frame_done c%0d", i), 32'(frame_done), (pos == 15) ? 32'h1 : 32'h0);
    end
    chk("postreset load_ready", 32'(load_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
